// File: rtl/pls_segment_scheduler.sv
// pls_segment_scheduler: walks the segment table and, for each segment, runs
// one transaction on the shared (a - b) / lines calculator, then writes the
// resulting increment into the playback increment table. A segment with
// zero lines skips the calculator and writes 0. A calculator watchdog
// aborts the pass.
module pls_segment_scheduler #(
   parameter int DATA_SIZE = 32,
   parameter int SEG_NUM   = 16,
   parameter int ADDR_W    = 4,
   parameter int TIMEOUT   = 1024
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic                 cfg_start,
   input  logic [ADDR_W:0]      cfg_seg_count,
   output logic [ADDR_W-1:0]    seg_rd_addr,
   input  logic [DATA_SIZE-1:0] seg_rd_a,
   input  logic [DATA_SIZE-1:0] seg_rd_b,
   input  logic [DATA_SIZE-1:0] seg_rd_lines,
   output logic                 calc_start,
   output logic [DATA_SIZE-1:0] calc_a,
   output logic [DATA_SIZE-1:0] calc_b,
   output logic [DATA_SIZE-1:0] calc_lines,
   input  logic                 calc_busy,
   input  logic [DATA_SIZE-1:0] calc_result,
   output logic                 inc_wr_en,
   output logic [ADDR_W-1:0]    inc_wr_addr,
   output logic [DATA_SIZE-1:0] inc_wr_data,
   output logic                 busy,
   output logic                 done,
   output logic                 err_zero_lines,
   output logic                 err_timeout
);

   localparam int CNT_W = ADDR_W + 1;
   localparam int WD_W  = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] SEG_MAX = CNT_W'(SEG_NUM);
   // Watchdog fires in the TIMEOUT-th cycle spent in a wait state
   localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_LATCH, S_REQ, S_WAIT, S_WRITE, S_RELEASE, S_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [ADDR_W-1:0]      idx_q, idx_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [WD_W-1:0]        wd_q, wd_d;
   logic [DATA_SIZE-1:0]   a_q, a_d;
   logic [DATA_SIZE-1:0]   b_q, b_d;
   logic [DATA_SIZE-1:0]   lines_q, lines_d;
   logic [DATA_SIZE-1:0]   wdata_q, wdata_d;
   logic                   ez_q, ez_d;
   logic                   et_q, et_d;
   logic                   last_seg;
   logic                   lines_zero;

   // Index is compared in count width so count == SEG_NUM still terminates
   assign last_seg   = ({1'b0, idx_q} == (cnt_q - CNT_W'(1)));
   // Both +0.0 and -0.0 count as zero lines
   assign lines_zero = (seg_rd_lines[DATA_SIZE-2:0] == '0);

   // State and datapath registers
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         wd_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         lines_q <= '0;
         wdata_q <= '0;
         ez_q    <= 1'b0;
         et_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         wd_q    <= wd_d;
         a_q     <= a_d;
         b_q     <= b_d;
         lines_q <= lines_d;
         wdata_q <= wdata_d;
         ez_q    <= ez_d;
         et_q    <= et_d;
      end
   end

   // Next-state, segment walk, watchdog and error flags
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      wd_d    = wd_q;
      a_d     = a_q;
      b_d     = b_q;
      lines_d = lines_q;
      wdata_d = wdata_q;
      ez_d    = ez_q;
      et_d    = et_q;
      case (state_q)
         S_IDLE: begin
            if (cfg_start) begin
               cnt_d   = (cfg_seg_count > SEG_MAX) ? SEG_MAX : cfg_seg_count;
               idx_d   = '0;
               ez_d    = 1'b0;
               et_d    = 1'b0;
               state_d = (cnt_d == '0) ? S_DONE : S_FETCH;
            end
         end
         S_FETCH: state_d = S_LATCH;
         S_LATCH: begin
            a_d     = seg_rd_a;
            b_d     = seg_rd_b;
            lines_d = seg_rd_lines;
            if (lines_zero) begin
               ez_d    = 1'b1;
               wdata_d = '0;
               state_d = S_WRITE;
            end else begin
               wd_d    = '0;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (calc_busy) begin
               wd_d    = '0;
               state_d = S_WAIT;
            end else if (wd_q == WD_LAST) begin
               et_d    = 1'b1;
               state_d = S_DONE;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
         end
         S_WAIT: begin
            if (!calc_busy) begin
               wdata_d = calc_result;
               state_d = S_WRITE;
            end else if (wd_q == WD_LAST) begin
               et_d    = 1'b1;
               state_d = S_DONE;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
         end
         S_WRITE: state_d = S_RELEASE;
         S_RELEASE: begin
            if (last_seg) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + ADDR_W'(1);
               state_d = S_FETCH;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from state; operands held in registers across the transaction
   always_comb begin
      calc_start     = (state_q == S_REQ) || (state_q == S_WAIT);
      inc_wr_en      = (state_q == S_WRITE);
      busy           = (state_q != S_IDLE) && (state_q != S_DONE);
      done           = (state_q == S_DONE);
      seg_rd_addr    = idx_q;
      inc_wr_addr    = idx_q;
      inc_wr_data    = wdata_q;
      calc_a         = a_q;
      calc_b         = b_q;
      calc_lines     = lines_q;
      err_zero_lines = ez_q;
      err_timeout    = et_q;
   end

endmodule

// File: doc/pls_segment_scheduler.md
Name: pls_segment_scheduler

Overview:
Sequences the per-segment increment calculation for the signal generator configuration path. After a configuration pass is requested, the block walks a segment table of start level, end level and line count. For each segment it runs one request/response transaction on the shared increment calculator, which computes (a - b) / lines in floating point. Each resulting increment is written into the increment table used by the playback datapath, with error and timeout supervision.

Parameters:
DATA_SIZE, 32, width of float operands and results
SEG_NUM, 16, maximum number of segments in the table
ADDR_W, 4, segment index width (clog2 of SEG_NUM)
TIMEOUT, 1024, max cycles allowed in any single calculator wait state

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
cfg_start  in  1  level; begins a pass when sampled high in IDLE
cfg_seg_count  in  ADDR_W+1  number of segments to process, 0..SEG_NUM
seg_rd_addr  out  ADDR_W  segment table read address
seg_rd_a  in  DATA_SIZE  segment end level (float); valid 1 cycle after address
seg_rd_b  in  DATA_SIZE  segment start level (float); same timing
seg_rd_lines  in  DATA_SIZE  segment line count (float); same timing
calc_start  out  1  calculator request, level
calc_a, calc_b, calc_lines  out  DATA_SIZE  calculator operands
calc_busy  in  1  calculator busy
calc_result  in  DATA_SIZE  calculator result, valid when busy falls
inc_wr_en  out  1  increment table write strobe
inc_wr_addr  out  ADDR_W  increment table address
inc_wr_data  out  DATA_SIZE  increment value
busy  out  1  pass in progress
done  out  1  one-cycle pulse at end of pass, including aborted passes
err_zero_lines  out  1  sticky; a segment had lines == 0
err_timeout  out  1  sticky; calculator watchdog expired

Behaviour:
- Reset (asynchronous, aresetn low): state IDLE. All outputs 0, including index, watchdog and sticky flags.
- States: IDLE, FETCH, LATCH, REQ, WAIT, WRITE, RELEASE, DONE.
- IDLE:
  - On cfg_start=1: latch cfg_seg_count (values above SEG_NUM are clamped to SEG_NUM), clear both sticky errors, index=0.
  - If the latched count is 0, go to DONE; otherwise go to FETCH.
  - cfg_start is ignored in every other state.
- FETCH: seg_rd_addr=index; go to LATCH.
- LATCH:
  - Register seg_rd_a/b/lines into calc_a/b/lines.
  - If seg_rd_lines[DATA_SIZE-2:0]==0 (float ±0): set err_zero_lines, set the write data to 0, go to WRITE without calling the calculator.
  - Otherwise go to REQ.
- REQ: calc_start=1; wait for calc_busy=1, then go to WAIT.
- WAIT: calc_start stays 1; on calc_busy=0, capture calc_result into inc_wr_data and go to WRITE.
- WRITE:
  - inc_wr_en=1 for exactly one cycle with inc_wr_addr=index.
  - calc_start=0 from this cycle on.
  - Go to RELEASE.
- RELEASE:
  - Hold calc_start=0 for at least one cycle so the calculator returns to idle.
  - If index == count-1, go to DONE; else index+1 and go to FETCH.
- DONE: done=1 for one cycle, busy=0, then go to IDLE.
- busy=1 in every state except IDLE and DONE.
- Per-segment latency with a calculator taking L busy cycles: 5 + L + (cycles until busy rises) cycles.
- Watchdog:
  - Counter cleared on entry to REQ and to WAIT; increments in those states.
  - On reaching TIMEOUT: set err_timeout, drive calc_start=0, go to DONE. No write for that segment; remaining segments are skipped.
- Operands are stable from LATCH through RELEASE.
- Arithmetic: index wraps never; the counter compares to count-1 using ADDR_W+1 bits.
- Reset mid-pass: immediate return to IDLE, calc_start=0, no partial write completes.

Test Plan:
- Segment 0 = {a=0x40400000 (3.0), b=0x3F800000 (1.0), lines=0x40800000 (4.0)}, count=1, calculator model with 3-cycle latency -> one write, addr 0, data 0x3F000000 (0.5); done pulse; busy low after; no errors.
- count=3 with distinct segments -> writes to addr 0,1,2 in order with correct quotients. calc_start returns to 0 for ≥1 cycle between each transaction. Exactly one done.
- count=0 -> done 2 cycles after cfg_start, no inc_wr_en, calc_start never asserted.
- Segment 1 lines=0x80000000 (-0.0), count=3 -> addr 1 written with 0, err_zero_lines=1, calculator not started for segment 1, segments 0 and 2 correct.
- Calculator model never raises busy, TIMEOUT=16 -> err_timeout=1 after 16 cycles in REQ, calc_start drops, done pulses, no write; next cfg_start clears err_timeout.
- aresetn asserted during WAIT of segment 2 -> all outputs 0 asynchronously, no write to addr 2; cfg_start held high during the pass has no effect until IDLE.
